// File: rtl/fp_add_norm_pkg.sv
// Shared constants, result-kind enum and rounding helper for the FP adder back half.
// Pipeline depth FPADD_LAT matches the three register stages in fp_add_norm.
package fp_add_norm_pkg;

    localparam int WEXP_DEF     = 8;
    localparam int WSIG_DEF     = 23;
    localparam int EXTRASIG_DEF = 3;
    localparam int FPADD_LAT    = 3;

    typedef enum logic [1:0] {
        KIND_NORMAL,
        KIND_ZERO,
        KIND_SPECIAL
    } kind_e;

    // Round-to-nearest-even increment decision.
    function automatic logic rne_up(input logic lsb, input logic g, input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fp_lzc #(
    parameter int W = 28,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  a,
    output logic [CW-1:0] cnt
);

    // Ascending scan: the highest set bit is the last to overwrite cnt.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (a[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_norm.sv
// FP adder back half: add/sub aligned mantissas, normalize, round RNE, pack. 3-stage pipeline.
// Define FPADD_FTZ_EN to flush denormal inputs and results to zero.
module fp_add_norm
    import fp_add_norm_pkg::*;
#(
    parameter int WEXP     = WEXP_DEF,
    parameter int WSIG     = WSIG_DEF,
    parameter int EXTRASIG = EXTRASIG_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WSIG+1:0]           x,
    input  logic [WSIG+EXTRASIG+1:0]  y,
    input  logic [WEXP-1:0]           bigexp,
    input  logic                      sign_big,
    input  logic                      eff_sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WEXP+WSIG:0]        result
);

    localparam int WX   = WSIG + 2;
    localparam int WM   = WSIG + EXTRASIG + 3;
    localparam int WN   = WM - 1;
    localparam int WK   = WSIG + 1;
    localparam int WE   = WEXP + 2;
    localparam int WR   = WEXP + WSIG + 1;
    localparam int LZW  = $clog2(WN + 1);
    localparam int GPOS = WN - WK - 1;
    localparam logic [WEXP-1:0] EXP_MAX = '1;

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ---------------- Stage 1: add / subtract ----------------
    logic [WM-1:0]   sum_c;
    logic [WSIG-1:0] pass_frac_c;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        if (eff_sub) sum_c = {1'b0, x, {EXTRASIG{1'b0}}} - {1'b0, y};
        else         sum_c = {1'b0, x, {EXTRASIG{1'b0}}} + {1'b0, y};
`ifdef FPADD_FTZ_EN
        if (!x[WX-1]) sum_c = '0;
`endif
        pass_frac_c = x[WSIG:1];
        if (pass_frac_c != '0) pass_frac_c[WSIG-1] = 1'b1;
    end

    logic            s1_valid, s1_sign, s1_special;
    logic [WM-1:0]   s1_m;
    logic [WEXP-1:0] s1_exp;
    logic [WSIG-1:0] s1_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_special <= 1'b0;
            s1_m       <= '0;
            s1_exp     <= '0;
            s1_frac    <= '0;
        end else if (advance) begin
            // NOTE: state uses non-blocking assignment so all stages shift on the same edge.
            s1_valid   <= in_valid;
            s1_sign    <= sign_big;
            s1_special <= (bigexp == EXP_MAX);
            s1_m       <= sum_c;
            s1_exp     <= bigexp;
            s1_frac    <= pass_frac_c;
        end
    end

    // ---------------- Stage 2: normalize ----------------
    logic [LZW-1:0] lz;

    fp_lzc #(.W(WN)) u_lzc (
        .a   (s1_m[WN-1:0]),
        .cnt (lz)
    );

    logic [WE-1:0] shift_max, shift_c, exp_c;
    logic [WN-1:0] norm_c;
    kind_e         kind_c;

    // Left shift stops at exponent 1; anything still unnormalized there is a denormal.
    always_comb begin
        shift_max = (s1_exp == '0) ? '0 : {2'b00, s1_exp - 1'b1};
        shift_c   = (WE'(lz) < shift_max) ? WE'(lz) : shift_max;
        norm_c    = s1_m[WN-1:0] << shift_c;
        exp_c     = {2'b00, s1_exp} - shift_c;
        if (s1_m[WM-1]) begin
            norm_c    = s1_m[WM-1:1];
            norm_c[0] = s1_m[1] | s1_m[0];
            exp_c     = {2'b00, s1_exp} + WE'(1);
        end
        if (s1_special)        kind_c = KIND_SPECIAL;
        else if (s1_m == '0)   kind_c = KIND_ZERO;
        else                   kind_c = KIND_NORMAL;
    end

    logic            s2_valid, s2_sign;
    logic [WN-1:0]   s2_n;
    logic [WE-1:0]   s2_e;
    kind_e           s2_kind;
    logic [WSIG-1:0] s2_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_n     <= '0;
            s2_e     <= '0;
            s2_kind  <= KIND_ZERO;
            s2_frac  <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_n     <= norm_c;
            s2_e     <= exp_c;
            s2_kind  <= kind_c;
            s2_frac  <= s1_frac;
        end
    end

    // ---------------- Stage 3: round and pack ----------------
    logic [WK-1:0] kept;
    logic [WK:0]   rnd;
    logic [WE-1:0] exp_r;
    logic          up, hidden;
    logic [WR-1:0] result_c;

    always_comb begin
        kept   = s2_n[WN-1 -: WK];
        up     = rne_up(kept[0], s2_n[GPOS], s2_n[GPOS-1], |s2_n[GPOS-2:0]);
        rnd    = {1'b0, kept} + {{WK{1'b0}}, up};
        exp_r  = rnd[WK] ? s2_e + WE'(1) : s2_e;
        hidden = rnd[WK] | rnd[WK-1];
        if (!hidden) begin
`ifdef FPADD_FTZ_EN
            result_c = {s2_sign, {(WR-1){1'b0}}};
`else
            result_c = {s2_sign, {WEXP{1'b0}}, rnd[WSIG-1:0]};
`endif
        end else if (exp_r >= {2'b00, EXP_MAX}) begin
            result_c = {s2_sign, EXP_MAX, {WSIG{1'b0}}};
        end else begin
            result_c = {s2_sign, exp_r[WEXP-1:0], rnd[WSIG-1:0]};
        end
        if (s2_kind == KIND_ZERO)    result_c = '0;
        if (s2_kind == KIND_SPECIAL) result_c = {s2_sign, EXP_MAX, s2_frac};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            result    <= result_c;
        end
    end

endmodule

// File: tb/tb_fp_add_norm.sv
// Scoreboard bench for fp_add_norm: a bench-side alignment model feeds directed vectors,
// a negedge monitor pops expected results as the DUT hands them over.
module tb_fp_add_norm;
    import fp_add_norm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] x = '0;
    logic [27:0] y = '0;
    logic [7:0]  bigexp = '0;
    logic        sign_big = 1'b0;
    logic        eff_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    fp_add_norm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .bigexp    (bigexp),
        .sign_big  (sign_big),
        .eff_sub   (eff_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          issue;
        bit          chk_lat;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef FPADD_FTZ_EN
    localparam logic [31:0] E_DN_SUB  = 32'h0000_0000;
    localparam logic [31:0] E_DN_ADD  = 32'h0000_0000;
    localparam logic [31:0] E_DN_NORM = 32'h0000_0000;
`else
    localparam logic [31:0] E_DN_SUB  = 32'h0000_0001;
    localparam logic [31:0] E_DN_ADD  = 32'h0000_0002;
    localparam logic [31:0] E_DN_NORM = 32'h0080_0000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Upstream alignment model: pick larger magnitude, right-shift the smaller with sticky.
    function automatic void align(input logic [31:0] a, input logic [31:0] b,
                                  output logic [24:0] ox, output logic [27:0] oy,
                                  output logic [7:0] oe, output logic os, output logic osub);
        logic [31:0] big, sml;
        logic [23:0] mb, ms;
        logic [7:0]  eb, es;
        logic [27:0] full;
        logic        st;
        int          d;
        if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
        else                    begin big = b; sml = a; end
        eb   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        es   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        mb   = {big[30:23] != 8'd0, big[22:0]};
        ms   = {sml[30:23] != 8'd0, sml[22:0]};
        d    = int'(eb) - int'(es);
        full = {ms, 4'b0000};
        st   = 1'b0;
        for (int i = 0; i < 28; i++) if (i < d) st = st | full[i];
        oy   = (d >= 28) ? 28'(st) : ((full >> d) | 28'(st));
        ox   = {mb, 1'b0};
        oe   = eb;
        os   = big[31];
        osub = a[31] ^ b[31];
    endfunction

    // Presents a+b, waits (bounded) for acceptance, queues the expected result.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                        input string name, input bit chk_lat);
        exp_t item;
        bit   done = 1'b0;
        align(a, b, x, y, bigexp, sign_big, eff_sub);
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                item.val = e; item.issue = cyc; item.chk_lat = chk_lat; item.name = name;
                sb_q.push_back(item);
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL %s_accept: in_ready never seen, required 1", name);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: compares each handed-over result and checks the output holds while stalled.
    logic        stalled = 1'b0;
    logic [31:0] held = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled && out_valid) check("stall_hold", result, held);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out: got 0x%08h, expected no output", result);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check(e.name, result, e.val);
                    if (e.chk_lat) check("latency", 32'(cyc - e.issue), 32'(FPADD_LAT));
                end
            end
            stalled = out_valid && !out_ready;
            held    = result;
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_result",    result,             32'd0);
        @(posedge clk);
        #1;

        send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, "one_plus_one", 1'b1);
        send(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, "one_minus_one", 1'b0);
        send(32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000, "neg_one_plus_one", 1'b0);
        send(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "rne_tie_even", 1'b0);
        send(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, "rne_tie_odd", 1'b0);
        send(32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, "rne_above_half", 1'b0);
        send(32'h3FFF_FFFF, 32'h3380_0000, 32'h4000_0000, "round_carry", 1'b0);
        send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "overflow_inf", 1'b0);
        send(32'h0080_0000, 32'h807F_FFFF, E_DN_SUB,      "denorm_sub", 1'b0);
        send(32'h0000_0001, 32'h0000_0001, E_DN_ADD,      "denorm_add", 1'b0);
        send(32'h0040_0000, 32'h0040_0000, E_DN_NORM,     "denorm_to_norm", 1'b0);
        send(32'h4040_0000, 32'hC020_0000, 32'h3F00_0000, "norm_shift", 1'b0);
        send(32'h3FC0_0000, 32'hBF00_0000, 32'h3F80_0000, "half_diff", 1'b0);
        send(32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000, "neg_result", 1'b0);
        send(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, "inf_pass", 1'b0);
        send(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0001, "nan_quiet", 1'b0);
        drain("drain_directed");

        // Backpressure: consumer stalls for 5 cycles while 4 operands are offered.
        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, "bp0", 1'b0);
                send(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "bp1", 1'b0);
                send(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, "bp2", 1'b0);
                send(32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000, "bp3", 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                check("in_ready_full", {31'b0, in_ready}, 32'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Reset pulse with two operations in flight.
        send(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, "flushed0", 1'b0);
        send(32'h3FC0_0000, 32'hBF00_0000, 32'h3F80_0000, "flushed1", 1'b0);
        rst_n = 1'b0;
        #12;
        sb_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        vcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        check("rst_flush_valid", 32'(vcnt), 32'd0);
        check("rst_flush_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(32'h4040_0000, 32'hC020_0000, 32'h3F00_0000, "after_reset", 1'b0);
        drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
